// File: rtl/mips_rf_pkg.sv
// Shared register-file constants for the MIPS datapath.
// Every read/write port sizes itself from these defaults.
package mips_rf_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_ADDR_W = 5;

  localparam logic [RF_ADDR_W-1:0] ZERO_ADDR = 5'd0;

endpackage

// File: rtl/mux_n_to_1.sv
// Generic N-to-1 word multiplexer over a packed input bus.
// Word k of the bus is din[k*WIDTH +: WIDTH].
module mux_n_to_1 #(
  parameter int WIDTH = 32,
  parameter int N     = 32,
  parameter int SEL_W = 5
) (
  input  logic [N*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   dout
);

  // Word select; a select beyond N yields zero so the output is never undefined
  always_comb begin
    if (int'(sel) < N) begin
      dout = din[int'(sel)*WIDTH +: WIDTH];
    end else begin
      dout = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: one synchronous write port and NUM_RD read ports,
// with optional zero register, write-first bypass and registered read data.
module reg_file_mp
  import mips_rf_pkg::*;
#(
  parameter  int WIDTH    = RF_WIDTH,
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int NUM_RD   = 2,
  parameter  int REG_RD   = 0,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

  logic [WIDTH-1:0]       mem_r [DEPTH];
  logic [DEPTH*WIDTH-1:0] mem_flat_s;
  logic                   wr_zero_s;
  logic                   eff_wr_s;

  // Write qualification; gating with reset keeps bypass silent while in reset
  always_comb begin
    wr_zero_s = (ZERO_REG != 0) && (wr_addr == ZERO_A);
    eff_wr_s  = reset && we && !wr_zero_s;
  end

  // Storage array with asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (eff_wr_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign mem_flat_s[i*WIDTH +: WIDTH] = mem_r[i];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic [WIDTH-1:0]  mux_s;
    logic [WIDTH-1:0]  val_s;
    logic              zero_s;
    logic              hit_s;

    assign addr_s = rd_addr[p*ADDR_W +: ADDR_W];

    mux_n_to_1 #(
      .WIDTH (WIDTH),
      .N     (DEPTH),
      .SEL_W (ADDR_W)
    ) u_mux (
      .din  (mem_flat_s),
      .sel  (addr_s),
      .dout (mux_s)
    );

    // Zero forcing has priority over the bypassed write data
    always_comb begin
      zero_s = (ZERO_REG != 0) && (addr_s == ZERO_A);
      hit_s  = (BYPASS != 0) && eff_wr_s && (wr_addr == addr_s);
      if (zero_s) begin
        val_s = {WIDTH{1'b0}};
      end else if (hit_s) begin
        val_s = wr_data;
      end else begin
        val_s = mux_s;
      end
    end

    if (REG_RD != 0) begin : g_reg
      logic [WIDTH-1:0] rd_r;

      // Read capture register, held while rd_en is low
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_r <= {WIDTH{1'b0}};
        end else if (rd_en[p]) begin
          rd_r <= val_s;
        end
      end

      assign rd_data[p*WIDTH +: WIDTH] = rd_r;
    end else begin : g_comb
      logic unused_en_s;
      assign unused_en_s               = rd_en[p];
      assign rd_data[p*WIDTH +: WIDTH] = val_s;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: three configurations share one random
// stimulus stream and are checked against an array-based reference model.
module tb_reg_file_mp;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [2:0]  en;
  logic [4:0]  ra0, ra1, ra2;
  logic [63:0] rd0;
  logic [95:0] rd1;
  logic [31:0] rd2;

  int n_checks = 0;
  int n_fail   = 0;

  // configuration table: 0 = comb default, 1 = registered depth 8, 2 = registered no bypass/zero
  int cfg_depth [3] = '{32, 8, 32};
  int cfg_nrd   [3] = '{2, 3, 1};
  int cfg_reg   [3] = '{0, 1, 1};
  int cfg_zero  [3] = '{1, 1, 0};
  int cfg_byp   [3] = '{1, 1, 0};

  logic [31:0] mm [3][32];
  logic [31:0] rr [3][3];
  logic [95:0] q0 [$];
  logic [95:0] q1 [$];
  logic [95:0] q2 [$];

  reg_file_mp dut0 (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wa), .wr_data(wd),
    .rd_en(en[1:0]), .rd_addr({ra1, ra0}), .rd_data(rd0)
  );

  reg_file_mp #(.DEPTH(8), .NUM_RD(3), .REG_RD(1)) dut1 (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wa[2:0]), .wr_data(wd),
    .rd_en(en), .rd_addr({ra2[2:0], ra1[2:0], ra0[2:0]}), .rd_data(rd1)
  );

  reg_file_mp #(.NUM_RD(1), .REG_RD(1), .ZERO_REG(0), .BYPASS(0)) dut2 (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wa), .wr_data(wd),
    .rd_en(en[0]), .rd_addr(ra0), .rd_data(rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int a = 0; a < 32; a++) mm[c][a] = 32'h0;
      for (int p = 0; p < 3; p++) rr[c][p] = 32'h0;
    end
  endtask

  function automatic bit model_wr(input int c);
    return we && !(cfg_zero[c] != 0 && (int'(wa) % cfg_depth[c]) == 0);
  endfunction

  // value a read of address a sees in this cycle, from the read rules
  function automatic logic [31:0] model_val(input int c, input int a);
    if (cfg_zero[c] != 0 && a == 0) return 32'h0;
    if (cfg_byp[c] != 0 && model_wr(c) && (int'(wa) % cfg_depth[c]) == a) return wd;
    return mm[c][a];
  endfunction

  // push expected outputs, then commit the write into the model
  task automatic model_step();
    logic [4:0]  ra [3];
    logic [95:0] e;
    logic [31:0] v;
    ra = '{ra0, ra1, ra2};
    for (int c = 0; c < 3; c++) begin
      e = 96'h0;
      for (int p = 0; p < cfg_nrd[c]; p++) begin
        v = model_val(c, int'(ra[p]) % cfg_depth[c]);
        if (cfg_reg[c] != 0) begin
          if (en[p]) rr[c][p] = v;
          e[p*32 +: 32] = rr[c][p];
        end else begin
          e[p*32 +: 32] = v;
        end
      end
      if (c == 0) q0.push_back(e);
      else if (c == 1) q1.push_back(e);
      else q2.push_back(e);
    end
    for (int c = 0; c < 3; c++) begin
      if (model_wr(c)) mm[c][int'(wa) % cfg_depth[c]] = wd;
    end
  endtask

  task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [2:0] e, input logic [4:0] r0, input logic [4:0] r1,
                     input logic [4:0] r2);
    @(negedge clk);
    we = w; wa = a; wd = d; en = e; ra0 = r0; ra1 = r1; ra2 = r2;
    model_step();
  endtask

  task automatic check_all_zero(input string nm);
    for (int p = 0; p < 2; p++) chk({nm, "_c"}, rd0[p*32 +: 32], 32'h0);
    for (int p = 0; p < 3; p++) chk({nm, "_r8"}, rd1[p*32 +: 32], 32'h0);
    chk({nm, "_nb"}, rd2, 32'h0);
  endtask

  // reset asserted mid-cycle with a write pending; writes must be ignored
  task automatic pulse_reset(input string nm);
    @(posedge clk);
    #3;
    reset = 1'b0;
    we = 1'b1; wa = 5'd5; wd = 32'h0BAD_0BAD; en = 3'b111;
    ra0 = 5'd5; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    model_reset();
    check_all_zero({nm, "_async"});
    @(posedge clk);
    #2;
    check_all_zero({nm, "_held"});
    @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  // combinational monitor, sampled mid low phase
  initial begin
    logic [95:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        for (int p = 0; p < 2; p++) chk($sformatf("comb_p%0d", p), rd0[p*32 +: 32], e[p*32 +: 32]);
      end
    end
  end

  // registered monitor, sampled just after the capturing edge
  initial begin
    logic [95:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        for (int p = 0; p < 3; p++) chk($sformatf("reg8_p%0d", p), rd1[p*32 +: 32], e[p*32 +: 32]);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("nobyp_p0", rd2, e[31:0]);
      end
    end
  end

  initial begin
    reset = 1'b0;
    we = 1'b0; wa = 5'd0; wd = 32'h0; en = 3'b000;
    ra0 = 5'd0; ra1 = 5'd0; ra2 = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    #2;
    reset = 1'b1;

    // reset clears a written register
    cyc(1'b1, 5'd5, 32'hDEAD_BEEF, 3'b111, 5'd5, 5'd5, 5'd5);
    cyc(1'b0, 5'd0, 32'h0, 3'b111, 5'd5, 5'd5, 5'd5);
    pulse_reset("rst");
    cyc(1'b0, 5'd0, 32'h0, 3'b111, 5'd5, 5'd5, 5'd5);
    cyc(1'b0, 5'd0, 32'h0, 3'b111, 5'd5, 5'd5, 5'd5);

    // zero register
    cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 3'b111, 5'd0, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 3'b111, 5'd0, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 3'b111, 5'd0, 5'd0, 5'd0);

    // bypass versus old value
    cyc(1'b1, 5'd7, 32'h11, 3'b000, 5'd0, 5'd0, 5'd0);
    cyc(1'b1, 5'd7, 32'h22, 3'b111, 5'd7, 5'd7, 5'd7);
    cyc(1'b0, 5'd0, 32'h0, 3'b000, 5'd7, 5'd7, 5'd7);
    cyc(1'b0, 5'd0, 32'h0, 3'b111, 5'd7, 5'd7, 5'd7);

    // multi-port fill and read
    for (int a = 1; a < 32; a++) cyc(1'b1, 5'(a), 32'(a) * 32'h0101_0101, 3'b000, 5'd0, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 3'b111, 5'd3, 5'd3, 5'd3);
    cyc(1'b0, 5'd0, 32'h0, 3'b111, 5'd31, 5'd1, 5'd6);

    // hold while rd_en is low
    cyc(1'b1, 5'd4, 32'h44, 3'b111, 5'd4, 5'd4, 5'd4);
    cyc(1'b0, 5'd0, 32'h0, 3'b111, 5'd4, 5'd4, 5'd4);
    cyc(1'b1, 5'd4, 32'h55, 3'b000, 5'd4, 5'd4, 5'd4);
    cyc(1'b0, 5'd0, 32'h0, 3'b000, 5'd4, 5'd4, 5'd4);
    cyc(1'b0, 5'd0, 32'h0, 3'b111, 5'd4, 5'd4, 5'd4);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (i == 5000) pulse_reset("rst_mid");
    end

    repeat (2) @(posedge clk);
    #3;
    n_checks++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size() + q2.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
